// File: rtl/key_command_filter_if.sv
// Keycode handshake between the HID keycode register, the command filter and the ball block.
interface key_command_filter_if;
  logic [7:0] keycode_in;
  logic [7:0] keycode_out;
  logic [7:0] held_code;
  logic       key_press;
  logic       key_release;
  logic [7:0] hold_frames;

  modport master (
    output keycode_in,
    input  keycode_out, held_code, key_press, key_release, hold_frames
  );

  modport slave (
    input  keycode_in,
    output keycode_out, held_code, key_press, key_release, hold_frames
  );
endinterface

// File: rtl/key_command_filter.sv
// Per-frame W/S/A/D keycode debouncer and command pulse generator for the ball block.
// Optional auto-repeat is compiled in when KEY_CMD_AUTOREPEAT_EN is defined.
module key_command_filter #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 30,
  parameter int unsigned REPEAT_PERIOD   = 6
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  key_command_filter_if.slave  cmd_if
);

  localparam logic [3:0] STABLE_MIN  = 4'(DEBOUNCE_FRAMES - 1);
`ifdef KEY_CMD_AUTOREPEAT_EN
  localparam logic [7:0] DELAY_LAST  = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1} state_t;
`endif

  function automatic logic [7:0] whitelist(input logic [7:0] code);
    case (code)
      8'h1A, 8'h16, 8'h04, 8'h07: whitelist = code;
      default:                    whitelist = 8'h00;
    endcase
  endfunction

  state_t     state_q;
  logic [7:0] prev_in_q, prev_in_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  logic [7:0] held_q;
  logic [7:0] kout_q;
  logic       press_q;
  logic       release_q;
  logic [7:0] hold_q;
`ifdef KEY_CMD_AUTOREPEAT_EN
  logic [7:0] rpt_cnt_q;
`endif
  logic       stable;
  logic [7:0] hold_sat_inc;

  // Sampler next-state and stability decode from the registered sampler state.
  always_comb begin
    prev_in_d = whitelist(cmd_if.keycode_in);
    run_cnt_d = 4'd0;
    if (prev_in_d != prev_in_q) begin
      run_cnt_d = 4'd0;
    end else if (run_cnt_q == 4'd15) begin
      run_cnt_d = 4'd15;
    end else begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
    stable       = (run_cnt_q >= STABLE_MIN);
    hold_sat_inc = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;
  end

  // Sampler registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prev_in_q <= 8'h00;
      run_cnt_q <= 4'd0;
    end else begin
      prev_in_q <= prev_in_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Press/hold/release FSM; pulse outputs fall back to zero every frame.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      held_q    <= 8'h00;
      kout_q    <= 8'h00;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 8'h00;
`ifdef KEY_CMD_AUTOREPEAT_EN
      rpt_cnt_q <= 8'h00;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      kout_q    <= 8'h00;
      case (state_q)
        IDLE: begin
          if (stable && (prev_in_q != 8'h00)) begin
            state_q <= HELD;
            held_q  <= prev_in_q;
            kout_q  <= prev_in_q;
            press_q <= 1'b1;
            hold_q  <= 8'h00;
          end else begin
            state_q <= IDLE;
          end
        end
        HELD: begin
          // Only a stable different code (including "no key") ends the hold.
          if (stable && (prev_in_q != held_q)) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 8'h00;
            hold_q    <= 8'h00;
          end else begin
            hold_q <= hold_sat_inc;
`ifdef KEY_CMD_AUTOREPEAT_EN
            if (hold_q == DELAY_LAST) begin
              state_q   <= REPEAT;
              kout_q    <= held_q;
              rpt_cnt_q <= 8'h00;
            end else begin
              state_q <= HELD;
            end
`else
            state_q <= HELD;
`endif
          end
        end
`ifdef KEY_CMD_AUTOREPEAT_EN
        REPEAT: begin
          if (stable && (prev_in_q != held_q)) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 8'h00;
            hold_q    <= 8'h00;
          end else begin
            hold_q <= hold_sat_inc;
            if (rpt_cnt_q == PERIOD_LAST) begin
              kout_q    <= held_q;
              rpt_cnt_q <= 8'h00;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 8'd1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          held_q  <= 8'h00;
          hold_q  <= 8'h00;
        end
      endcase
    end
  end

  assign cmd_if.keycode_out = kout_q;
  assign cmd_if.held_code   = held_q;
  assign cmd_if.key_press   = press_q;
  assign cmd_if.key_release = release_q;
  assign cmd_if.hold_frames = hold_q;

endmodule

// File: tb/tb_key_command_filter.sv
// Self-checking bench: directed scenarios with fixed expectations plus randomized
// keycode streams compared against a frame-history reference model.
module tb_key_command_filter;
  localparam int DEB = 2;
  localparam int RD  = 30;
  localparam int RP  = 6;
`ifdef KEY_CMD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic frame_clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  key_command_filter_if kif();

  key_command_filter #(
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .cmd_if   (kif)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Reference model: history of filtered samples, unbounded frames-since-press count.
  logic [7:0] hist [0:15];
  int         hist_len;
  logic [7:0] m_held;
  int         m_cnt;
  logic [7:0] e_kout;
  logic [7:0] e_hold;
  logic       e_press;
  logic       e_rel;
  logic       m_stable;
  logic       m_rpt;

  function automatic logic [7:0] wl(input logic [7:0] c);
    return (c == 8'h1A || c == 8'h16 || c == 8'h04 || c == 8'h07) ? c : 8'h00;
  endfunction

  always_comb begin
    m_stable = (hist_len >= DEB);
    for (int i = 0; i < DEB; i++) begin
      if (hist[i] != hist[0]) m_stable = 1'b0;
    end
    m_rpt = AR && ((m_cnt + 1) >= RD) && (((m_cnt + 1 - RD) % RP) == 0);
  end

  always @(posedge frame_clk) begin
    if (Reset) begin
      hist[0]  <= 8'h00;
      hist_len <= 1;
      m_held   <= 8'h00;
      m_cnt    <= 0;
      e_kout   <= 8'h00;
      e_hold   <= 8'h00;
      e_press  <= 1'b0;
      e_rel    <= 1'b0;
    end else begin
      for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
      hist[0]  <= wl(kif.keycode_in);
      hist_len <= (hist_len < 16) ? hist_len + 1 : 16;
      e_press  <= 1'b0;
      e_rel    <= 1'b0;
      e_kout   <= 8'h00;
      if (m_held == 8'h00) begin
        if (m_stable && hist[0] != 8'h00) begin
          m_held  <= hist[0];
          e_kout  <= hist[0];
          e_press <= 1'b1;
          m_cnt   <= 0;
          e_hold  <= 8'h00;
        end
      end else if (m_stable && hist[0] != m_held) begin
        m_held <= 8'h00;
        e_rel  <= 1'b1;
        m_cnt  <= 0;
        e_hold <= 8'h00;
      end else begin
        m_cnt  <= m_cnt + 1;
        e_hold <= (m_cnt >= 254) ? 8'hFF : 8'(m_cnt + 1);
        if (m_rpt) e_kout <= m_held;
      end
    end
  end

  task automatic tick(input logic [7:0] code);
    kif.keycode_in = code;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 6; i++) tick(8'h00);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(8'h1A);
    tick(8'h1A);
    n_checks++;
    if ({kif.keycode_out, kif.held_code, kif.key_press, kif.key_release, kif.hold_frames} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state: got kout=%h held=%h press=%b rel=%b hold=%0d, want all zero",
               kif.keycode_out, kif.held_code, kif.key_press, kif.key_release, kif.hold_frames);
    end
    Reset = 1'b0;
    settle();
  endtask

  task automatic test_press_latency();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] x_kout, x_held, x_hold;
      logic       x_press;
      tick(8'h1A);
      x_press = (i == 2);
      x_kout  = (i == 2) ? 8'h1A : 8'h00;
      x_held  = (i >= 2) ? 8'h1A : 8'h00;
      x_hold  = (i >= 2) ? 8'(i - 2) : 8'h00;
      n_checks++;
      if ({kif.key_press, kif.keycode_out, kif.held_code, kif.hold_frames} !== {x_press, x_kout, x_held, x_hold}) begin
        n_fail++;
        $display("FAIL press_latency frame %0d: got press=%b kout=%h held=%h hold=%0d, want press=%b kout=%h held=%h hold=%0d",
                 i, kif.key_press, kif.keycode_out, kif.held_code, kif.hold_frames, x_press, x_kout, x_held, x_hold);
      end
    end
  endtask

  task automatic test_bounce();
    settle();
    for (int i = 0; i < 10; i++) begin
      tick((i % 2 == 0) ? 8'h07 : 8'h00);
      n_checks++;
      if (kif.key_press !== 1'b0 || kif.keycode_out !== 8'h00) begin
        n_fail++;
        $display("FAIL bounce frame %0d: got press=%b kout=%h, want press=0 kout=00",
                 i, kif.key_press, kif.keycode_out);
      end
    end
  endtask

  task automatic test_hold_repeat();
    settle();
    for (int i = 0; i < 50; i++) begin
      int         off;
      logic [7:0] x_kout;
      tick(8'h04);
      off    = i - DEB;
      x_kout = ((off == 0) || (AR && off >= RD && ((off - RD) % RP) == 0)) ? 8'h04 : 8'h00;
      n_checks++;
      if (kif.keycode_out !== x_kout) begin
        n_fail++;
        $display("FAIL hold_repeat frame %0d: got kout=%h, want kout=%h", i, kif.keycode_out, x_kout);
      end
    end
  endtask

  task automatic test_key_change();
    settle();
    for (int i = 0; i < 5; i++) tick(8'h16);
    for (int i = 0; i < 4; i++) begin
      logic       x_press, x_rel;
      logic [7:0] x_held, x_kout;
      tick(8'h1A);
      x_rel   = (i == 2);
      x_press = (i == 3);
      x_held  = (i < 2) ? 8'h16 : ((i == 3) ? 8'h1A : 8'h00);
      x_kout  = (i == 3) ? 8'h1A : 8'h00;
      n_checks++;
      if ({kif.key_press, kif.key_release, kif.held_code, kif.keycode_out} !== {x_press, x_rel, x_held, x_kout}) begin
        n_fail++;
        $display("FAIL key_change frame %0d: got press=%b rel=%b held=%h kout=%h, want press=%b rel=%b held=%h kout=%h",
                 i, kif.key_press, kif.key_release, kif.held_code, kif.keycode_out, x_press, x_rel, x_held, x_kout);
      end
    end
  endtask

  task automatic test_nonwhitelist();
    for (int i = 0; i < 20; i++) begin
      logic       x_rel;
      logic [7:0] x_held;
      tick(8'h2C);
      x_rel  = (i == DEB);
      x_held = (i < DEB) ? 8'h1A : 8'h00;
      n_checks++;
      if ({kif.key_press, kif.key_release, kif.held_code} !== {1'b0, x_rel, x_held}) begin
        n_fail++;
        $display("FAIL nonwhitelist frame %0d: got press=%b rel=%b held=%h, want press=0 rel=%b held=%h",
                 i, kif.key_press, kif.key_release, kif.held_code, x_rel, x_held);
      end
    end
  endtask

  task automatic test_reset_midhold();
    settle();
    for (int i = 0; i < 200 && kif.hold_frames !== 8'd100; i++) tick(8'h07);
    n_checks++;
    if (kif.hold_frames !== 8'd100) begin
      n_fail++;
      $display("FAIL reach_hold100: got hold=%0d, want hold=100 within 200 frames", kif.hold_frames);
    end
    Reset = 1'b1;
    tick(8'h07);
    n_checks++;
    if ({kif.keycode_out, kif.held_code, kif.key_press, kif.key_release, kif.hold_frames} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_midhold: got kout=%h held=%h press=%b rel=%b hold=%0d, want all zero",
               kif.keycode_out, kif.held_code, kif.key_press, kif.key_release, kif.hold_frames);
    end
    Reset = 1'b0;
    for (int i = 0; i < 300; i++) tick(8'h07);
    n_checks++;
    if (kif.hold_frames !== 8'hFF || kif.held_code !== 8'h07) begin
      n_fail++;
      $display("FAIL hold_saturate: got hold=%0d held=%h, want hold=255 held=07", kif.hold_frames, kif.held_code);
    end
  endtask

  task automatic test_random();
    int cyc;
    cyc = 0;
    while (cyc < 3000) begin
      int         sel, len;
      logic [7:0] code;
      sel = $urandom_range(0, 7);
      len = $urandom_range(1, 45);
      case (sel)
        0:       code = 8'h00;
        1:       code = 8'h1A;
        2:       code = 8'h16;
        3:       code = 8'h04;
        4:       code = 8'h07;
        5:       code = 8'h2C;
        default: code = 8'($urandom_range(0, 255));
      endcase
      Reset = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < len; k++) begin
        tick((sel == 7 && (k % 2 == 1)) ? 8'h00 : code);
        Reset = 1'b0;
        cyc++;
        n_checks++;
        if ({kif.keycode_out, kif.held_code, kif.key_press, kif.key_release, kif.hold_frames} !==
            {e_kout, m_held, e_press, e_rel, e_hold}) begin
          n_fail++;
          $display("FAIL random_model cycle %0d: got kout=%h held=%h press=%b rel=%b hold=%0d, want kout=%h held=%h press=%b rel=%b hold=%0d",
                   cyc, kif.keycode_out, kif.held_code, kif.key_press, kif.key_release, kif.hold_frames,
                   e_kout, m_held, e_press, e_rel, e_hold);
        end
      end
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    Reset          = 1'b1;
    kif.keycode_in = 8'h00;
    test_reset();
    test_press_latency();
    test_bounce();
    test_hold_repeat();
    test_key_change();
    test_nonwhitelist();
    test_reset_midhold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
